// File: rtl/param_pkg.sv
// Shared types and default sizes for the coherence directory responder.
package param_pkg;

  localparam int DIR_N_CPU        = 4;
  localparam int DIR_TAG_WIDTH    = 8;
  localparam int DIR_INDEX_WIDTH  = 4;
  localparam int DIR_CPU_ID_WIDTH = 3;

  typedef enum logic [2:0] {
    READ_OP          = 3'd0,
    ADD_SHARER_OP    = 3'd1,
    REMOVE_SHARER_OP = 3'd2,
    SET_EXCL_OP      = 3'd3,
    INVAL_OP         = 3'd4
  } op_dir_t;

  typedef struct packed {
    logic                     valid;
    logic [DIR_TAG_WIDTH-1:0] tag;
    logic [DIR_N_CPU-1:0]     sharers;
  } dir_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    RESP,
    GAP
  } dir_state_t;

endpackage

// File: rtl/dir_mem_array.sv
// Direct-mapped directory storage: registered read, single write port.
// Only the valid bits are reset; tag and sharer storage stay as plain RAM.
module dir_mem_array #(
  parameter int N_CPU       = param_pkg::DIR_N_CPU,
  parameter int TAG_WIDTH   = param_pkg::DIR_TAG_WIDTH,
  parameter int INDEX_WIDTH = param_pkg::DIR_INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rd_en,
  input  logic [INDEX_WIDTH-1:0] rd_addr,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_addr,
  input  logic                   wr_valid,
  input  logic [TAG_WIDTH-1:0]   wr_tag,
  input  logic [N_CPU-1:0]       wr_sharers,
  output logic                   rd_valid,
  output logic [TAG_WIDTH-1:0]   rd_tag,
  output logic [N_CPU-1:0]       rd_sharers
);

  localparam int DEPTH = 1 << INDEX_WIDTH;

  logic [DEPTH-1:0]     valid_bits;
  logic [TAG_WIDTH-1:0] tag_mem     [DEPTH];
  logic [N_CPU-1:0]     sharers_mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_bits <= '0;
      rd_valid   <= 1'b0;
    end else begin
      if (wr_en) valid_bits[wr_addr] <= wr_valid;
      if (rd_en) rd_valid <= valid_bits[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_addr]     <= wr_tag;
      sharers_mem[wr_addr] <= wr_sharers;
    end
    if (rd_en) begin
      rd_tag     <= tag_mem[rd_addr];
      rd_sharers <= sharers_mem[rd_addr];
    end
  end

endmodule

// File: rtl/dir_mem.sv
// Coherence directory responder: lookup, one-cycle ack with old sharers, update.
// Optional DIR_MEM_CHECK_EN adds a sticky err_o protocol-error flag.
module dir_mem
  import param_pkg::*;
#(
  parameter int N_CPU              = param_pkg::DIR_N_CPU,
  parameter int DCACHE_TAG_WIDTH   = param_pkg::DIR_TAG_WIDTH,
  parameter int DCACHE_INDEX_WIDTH = param_pkg::DIR_INDEX_WIDTH,
  parameter int CPU_ID_WIDTH       = param_pkg::DIR_CPU_ID_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_i,
  input  op_dir_t                       op_i,
  input  logic [DCACHE_TAG_WIDTH-1:0]   tag_i,
  input  logic [DCACHE_INDEX_WIDTH-1:0] index_i,
  input  logic [CPU_ID_WIDTH-1:0]       cpu_id_i,
  output logic                          ack_o,
`ifdef DIR_MEM_CHECK_EN
  output logic                          err_o,
`endif
  output logic [N_CPU-1:0]              sharers_o
);

  dir_state_t                    state_reg, state_next;
  op_dir_t                       op_reg;
  logic [DCACHE_TAG_WIDTH-1:0]   tag_reg;
  logic [DCACHE_INDEX_WIDTH-1:0] index_reg;
  logic [CPU_ID_WIDTH-1:0]       cpu_reg;
  logic                          ack_reg;
  logic [N_CPU-1:0]              sharers_reg;
  logic                          wr_en_reg;
  logic                          wr_valid_reg;
  logic [N_CPU-1:0]              wr_sharers_reg;

  logic                          rd_en;
  logic                          rd_valid;
  logic [DCACHE_TAG_WIDTH-1:0]   rd_tag;
  logic [N_CPU-1:0]              rd_sharers;

  logic                          hit;
  logic                          cpu_ok;
  logic [N_CPU-1:0]              mask;
  logic [N_CPU-1:0]              old_sharers;
  logic                          upd_en;
  logic                          upd_valid;
  logic [N_CPU-1:0]              upd_sharers;

  // The RAM read is launched with the live index on the accepting edge so the
  // entry is already registered while the FSM sits in LOOKUP.
  assign rd_en = (state_reg == IDLE) && valid_i;

  dir_mem_array #(
    .N_CPU      (N_CPU),
    .TAG_WIDTH  (DCACHE_TAG_WIDTH),
    .INDEX_WIDTH(DCACHE_INDEX_WIDTH)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .rd_en     (rd_en),
    .rd_addr   (index_i),
    .wr_en     (wr_en_reg),
    .wr_addr   (index_reg),
    .wr_valid  (wr_valid_reg),
    .wr_tag    (tag_reg),
    .wr_sharers(wr_sharers_reg),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_sharers(rd_sharers)
  );

  // Out-of-range cpu ids produce an all-zero mask, so bit ops leave the vector alone.
  generate
    for (genvar gi = 0; gi < N_CPU; gi++) begin : g_mask
      assign mask[gi] = (int'(cpu_reg) == gi);
    end
  endgenerate

  assign cpu_ok      = int'(cpu_reg) < N_CPU;
  assign hit         = rd_valid && (rd_tag == tag_reg);
  assign old_sharers = hit ? rd_sharers : '0;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (valid_i) state_next = LOOKUP;
      LOOKUP:  state_next = RESP;
      RESP:    state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    upd_en      = 1'b0;
    upd_valid   = 1'b1;
    upd_sharers = old_sharers;
    case (op_reg)
      ADD_SHARER_OP: begin
        upd_sharers = old_sharers | mask;
        upd_en      = 1'b1;
      end
      REMOVE_SHARER_OP: begin
        upd_sharers = old_sharers & ~mask;
        upd_en      = hit;
        upd_valid   = |(old_sharers & ~mask);
      end
      SET_EXCL_OP: begin
        upd_sharers = cpu_ok ? mask : old_sharers;
        upd_en      = 1'b1;
      end
      INVAL_OP: begin
        upd_en    = hit;
        upd_valid = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      ack_reg     <= 1'b0;
      sharers_reg <= '0;
      wr_en_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ack_reg     <= (state_reg == LOOKUP);
      sharers_reg <= (state_reg == LOOKUP) ? old_sharers : '0;
      wr_en_reg   <= (state_reg == LOOKUP) && upd_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      op_reg    <= op_i;
      tag_reg   <= tag_i;
      index_reg <= index_i;
      cpu_reg   <= cpu_id_i;
    end
    if (state_reg == LOOKUP) begin
      wr_valid_reg   <= upd_valid;
      wr_sharers_reg <= upd_sharers;
    end
  end

  assign ack_o     = ack_reg;
  assign sharers_o = sharers_reg;

`ifdef DIR_MEM_CHECK_EN
  logic err_reg;
  logic err_cond;

  always_comb begin
    err_cond = !cpu_ok
            || !(op_reg inside {READ_OP, ADD_SHARER_OP, REMOVE_SHARER_OP, SET_EXCL_OP, INVAL_OP})
            || ((op_reg == REMOVE_SHARER_OP) && ((old_sharers & mask) == '0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_reg <= 1'b0;
    else if ((state_reg == LOOKUP) && err_cond) err_reg <= 1'b1;
  end

  assign err_o = err_reg;
`endif

endmodule

// File: tb/tb_dir_mem.sv
// Scoreboard bench for dir_mem: driver queues expected sharers, monitor checks acks.
// With DIR_MEM_CHECK_EN defined the err_o checks are compiled in as well.
module tb_dir_mem;
  import param_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_i;
  op_dir_t    op_i;
  logic [7:0] tag_i;
  logic [3:0] index_i;
  logic [2:0] cpu_id_i;
  logic       ack_o;
  logic [3:0] sharers_o;
`ifdef DIR_MEM_CHECK_EN
  logic       err_o;
`endif

  always #5 clk = ~clk;

  dir_mem #(
    .N_CPU(4), .DCACHE_TAG_WIDTH(8), .DCACHE_INDEX_WIDTH(4), .CPU_ID_WIDTH(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (valid_i),
    .op_i     (op_i),
    .tag_i    (tag_i),
    .index_i  (index_i),
    .cpu_id_i (cpu_id_i),
    .ack_o    (ack_o),
`ifdef DIR_MEM_CHECK_EN
    .err_o    (err_o),
`endif
    .sharers_o(sharers_o)
  );

  int         vectors    = 0;
  int         miscompares = 0;
  int         req_id     = 0;
  logic [3:0] exp_q[$];
  int         id_q[$];

  // Monitor: pops one expectation per ack and checks idle outputs stay zero.
  always @(negedge clk) begin
    if (!reset) begin
      if (ack_o) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_ack: sharers_o=%b, required no ack", sharers_o);
        end else begin
          logic [3:0] e;
          int         id;
          e  = exp_q.pop_front();
          id = id_q.pop_front();
          if (sharers_o !== e) begin
            miscompares++;
            $display("FAIL req%0d_sharers: got %b, required %b", id, sharers_o, e);
          end else begin
            $display("req %0d: sharers_o=%b as expected", id, sharers_o);
          end
        end
      end else if (sharers_o !== 4'b0000) begin
        miscompares++;
        $display("FAIL idle_sharers: got %b, required 0000", sharers_o);
      end
    end
  end

  task automatic req(input op_dir_t op, input logic [7:0] tag, input logic [3:0] idx,
                     input logic [2:0] cpu, input logic [3:0] exp, input bit hold);
    int n;
    @(negedge clk);
    valid_i  = 1'b1;
    op_i     = op;
    tag_i    = tag;
    index_i  = idx;
    cpu_id_i = cpu;
    exp_q.push_back(exp);
    id_q.push_back(req_id);
    n = 0;
    while (n < 8) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        // Scramble the request fields once captured; they must no longer matter.
        op_i     = READ_OP;
        tag_i    = ~tag;
        index_i  = ~idx;
        cpu_id_i = ~cpu;
      end
      if (ack_o) break;
    end
    vectors++;
    if (!ack_o || n != 2) begin
      miscompares++;
      $display("FAIL req%0d_latency: ack after %0d cycles (ack=%b), required 2", req_id, n, ack_o);
    end
    if (hold) repeat (2) @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    req_id++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    valid_i  = 1'b0;
    op_i     = READ_OP;
    tag_i    = '0;
    index_i  = '0;
    cpu_id_i = '0;
    @(negedge clk);
    vectors++;
    if (ack_o !== 1'b0 || sharers_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_outputs: ack=%b sharers=%b, required 0 and 0000", ack_o, sharers_o);
    end
`ifdef DIR_MEM_CHECK_EN
    vectors++;
    if (err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_err: got %b, required 0", err_o);
    end
`endif
    @(negedge clk);
    reset = 1'b0;

    req(READ_OP,          8'h12, 4'd3, 3'd0, 4'b0000, 1'b0);
    req(ADD_SHARER_OP,    8'h12, 4'd3, 3'd1, 4'b0000, 1'b0);
    req(ADD_SHARER_OP,    8'h12, 4'd3, 3'd2, 4'b0010, 1'b0);
    req(READ_OP,          8'h12, 4'd3, 3'd0, 4'b0110, 1'b0);
    req(SET_EXCL_OP,      8'h12, 4'd3, 3'd0, 4'b0110, 1'b0);
    req(READ_OP,          8'h12, 4'd3, 3'd0, 4'b0001, 1'b0);
    req(ADD_SHARER_OP,    8'h34, 4'd3, 3'd3, 4'b0000, 1'b0);
    req(READ_OP,          8'h12, 4'd3, 3'd0, 4'b0000, 1'b0);
    req(READ_OP,          8'h34, 4'd3, 3'd0, 4'b1000, 1'b0);
    req(REMOVE_SHARER_OP, 8'h34, 4'd3, 3'd3, 4'b1000, 1'b0);
    req(READ_OP,          8'h34, 4'd3, 3'd0, 4'b0000, 1'b0);
    req(ADD_SHARER_OP,    8'h12, 4'd3, 3'd2, 4'b0000, 1'b1);
    req(READ_OP,          8'h12, 4'd3, 3'd0, 4'b0100, 1'b1);
    req(REMOVE_SHARER_OP, 8'h12, 4'd3, 3'd1, 4'b0100, 1'b0);
    req(READ_OP,          8'h12, 4'd3, 3'd0, 4'b0100, 1'b0);
    req(INVAL_OP,         8'h12, 4'd3, 3'd0, 4'b0100, 1'b0);
    req(READ_OP,          8'h12, 4'd3, 3'd0, 4'b0000, 1'b0);
    req(ADD_SHARER_OP,    8'h12, 4'd7, 3'd3, 4'b0000, 1'b0);
    req(op_dir_t'(3'd6),  8'h12, 4'd7, 3'd1, 4'b1000, 1'b0);
    req(READ_OP,          8'h12, 4'd7, 3'd0, 4'b1000, 1'b0);
    req(READ_OP,          8'h12, 4'd3, 3'd0, 4'b0000, 1'b0);

    // Reset while an ADD sits in LOOKUP: no ack, no write, all entries invalid.
    @(negedge clk);
    valid_i  = 1'b1;
    op_i     = ADD_SHARER_OP;
    tag_i    = 8'h77;
    index_i  = 4'd5;
    cpu_id_i = 3'd1;
    @(negedge clk);
    reset   = 1'b1;
    valid_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (ack_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_lookup_ack: got %b, required 0", ack_o);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    req(READ_OP, 8'h77, 4'd5, 3'd0, 4'b0000, 1'b0);
    req(READ_OP, 8'h12, 4'd7, 3'd0, 4'b0000, 1'b0);

`ifdef DIR_MEM_CHECK_EN
    req(REMOVE_SHARER_OP, 8'h55, 4'd9, 3'd1, 4'b0000, 1'b0);
    vectors++;
    if (err_o !== 1'b1) begin
      miscompares++;
      $display("FAIL err_remove_miss: got %b, required 1", err_o);
    end
    req(READ_OP, 8'h55, 4'd9, 3'd0, 4'b0000, 1'b0);
    vectors++;
    if (err_o !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: got %b, required 1", err_o);
    end
    do_reset();
    vectors++;
    if (err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL err_cleared: got %b, required 0", err_o);
    end
    req(ADD_SHARER_OP, 8'h55, 4'd9, 3'd5, 4'b0000, 1'b0);
    vectors++;
    if (err_o !== 1'b1) begin
      miscompares++;
      $display("FAIL err_bad_cpu: got %b, required 1", err_o);
    end
`endif

    repeat (5) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_acks: %0d expected acks never seen, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
